axis_fifo_param: RTL and testbench

//  Parametrised AXI-stream FIFO with first-word-fall-through (FWFT) behaviour,

---
 rtl/axis_fifo_param.sv | 109 ++++++++++
 tb/tb_axis_fifo_param.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_fifo_param.sv
// Parametrised AXI-stream FWFT FIFO: array storage plus one registered output
// stage, with TLAST, almost-full/empty flags, flush, occupancy and high-water mark.
module axis_fifo_param #(
  parameter int DATA_WIDTH    = 32,
  parameter int DEPTH         = 256,
  parameter int AFULL_THRESH  = 240,
  parameter int AEMPTY_THRESH = 2,
  localparam int CNT_W        = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tlast,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [CNT_W-1:0]      occupancy,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [CNT_W-1:0]      hwm,
  input  logic                  hwm_clr
);

  localparam int ADDR_W = $clog2(DEPTH);

  logic [DATA_WIDTH:0] mem [DEPTH];
  logic [ADDR_W:0]     wr_ptr, rd_ptr;
  logic [CNT_W-1:0]    occ, occ_next, hwm_q;
  logic                out_of_reset;
  logic                full, arr_empty, push, pop;
  logic                load_direct, load_arr, wr_en;

  assign full          = (occ == CNT_W'(DEPTH));
  assign s_axis_tready = out_of_reset & ~full & ~flush;
  assign push          = s_axis_tvalid & s_axis_tready;
  assign pop           = m_axis_tvalid & m_axis_tready;
  assign arr_empty     = (wr_ptr == rd_ptr);
  assign occupancy     = occ;
  assign hwm           = hwm_q;

  // A push bypasses the array only when the output stage will be free and nothing is queued
  assign load_direct = push & (~m_axis_tvalid | (pop & arr_empty));
  assign load_arr    = pop & ~arr_empty;
  assign wr_en       = push & ~load_direct;

  always_comb begin
    occ_next = occ;
    if (push && !pop)
      occ_next = occ + CNT_W'(1);
    else if (pop && !push)
      occ_next = occ - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_ptr[ADDR_W-1:0]] <= {s_axis_tlast, s_axis_tdata};
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      out_of_reset  <= 1'b0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
      occ           <= '0;
      hwm_q         <= '0;
      almost_full   <= 1'b0;
      almost_empty  <= 1'b1;
    end else begin
      out_of_reset <= 1'b1;
      if (flush) begin
        wr_ptr        <= '0;
        rd_ptr        <= '0;
        m_axis_tvalid <= 1'b0;
        occ           <= '0;
        hwm_q         <= '0;
        almost_full   <= 1'b0;
        almost_empty  <= 1'b1;
      end else begin
        if (wr_en)
          wr_ptr <= wr_ptr + 1'b1;
        if (load_arr) begin
          {m_axis_tlast, m_axis_tdata} <= mem[rd_ptr[ADDR_W-1:0]];
          rd_ptr        <= rd_ptr + 1'b1;
          m_axis_tvalid <= 1'b1;
        end else if (load_direct) begin
          {m_axis_tlast, m_axis_tdata} <= {s_axis_tlast, s_axis_tdata};
          m_axis_tvalid <= 1'b1;
        end else if (pop) begin
          m_axis_tvalid <= 1'b0;
        end
        occ          <= occ_next;
        almost_full  <= (occ_next >= CNT_W'(AFULL_THRESH));
        almost_empty <= (occ_next <= CNT_W'(AEMPTY_THRESH));
        if (hwm_clr)
          hwm_q <= occ_next;
        else if (occ_next > hwm_q)
          hwm_q <= occ_next;
      end
    end
  end

endmodule

// File: tb/tb_axis_fifo_param.sv
// Self-checking bench for axis_fifo_param (DEPTH=16): directed scenarios plus a
// negedge scoreboard monitor that checks ordering, occupancy and flags every cycle.
module tb_axis_fifo_param;

  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int AF    = 12;
  localparam int AE    = 2;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          flush = 1'b0;
  logic [DW-1:0] s_axis_tdata = '0;
  logic          s_axis_tlast = 1'b0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tready;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tlast;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b0;
  logic [CW-1:0] occupancy;
  logic          almost_full;
  logic          almost_empty;
  logic [CW-1:0] hwm;
  logic          hwm_clr = 1'b0;

  int total = 0;
  int bad   = 0;

  // scoreboard and reference model state (state after the most recent edge)
  logic [DW:0] sb[$];
  int          model_occ = 0;
  int          model_hwm = 0;
  bit          model_oor = 1'b0;
  bit          model_valid = 1'b0;
  bit          held = 1'b0;
  logic [DW:0] held_word;

  axis_fifo_param #(
    .DATA_WIDTH(DW), .DEPTH(DEPTH), .AFULL_THRESH(AF), .AEMPTY_THRESH(AE)
  ) dut (
    .clk(clk), .rstn(rstn), .flush(flush),
    .s_axis_tdata(s_axis_tdata), .s_axis_tlast(s_axis_tlast),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .occupancy(occupancy), .almost_full(almost_full), .almost_empty(almost_empty),
    .hwm(hwm), .hwm_clr(hwm_clr)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic sv, input logic [DW-1:0] sd, input logic sl,
                               input logic mr, input logic fl, input logic clr);
    s_axis_tvalid = sv;
    s_axis_tdata  = sd;
    s_axis_tlast  = sl;
    m_axis_tready = mr;
    flush         = fl;
    hwm_clr       = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic checkReset();
    checkOutput("rst_s_tready", s_axis_tready, 0);
    checkOutput("rst_m_tvalid", m_axis_tvalid, 0);
    checkOutput("rst_m_tdata", m_axis_tdata, 0);
    checkOutput("rst_m_tlast", m_axis_tlast, 0);
    checkOutput("rst_occupancy", occupancy, 0);
    checkOutput("rst_hwm", hwm, 0);
    checkOutput("rst_almost_full", almost_full, 0);
    checkOutput("rst_almost_empty", almost_empty, 1);
  endtask

  // Monitor: inputs seen at negedge are exactly those sampled at the next posedge
  always @(negedge clk) begin
    logic do_push, do_pop;
    logic [DW:0] exp_w;
    int occ_n;
    if (model_valid) begin
      checkOutput("mon_occupancy", occupancy, model_occ);
      checkOutput("mon_almost_full", almost_full, model_occ >= AF);
      checkOutput("mon_almost_empty", almost_empty, model_occ <= AE);
      checkOutput("mon_hwm", hwm, model_hwm);
      checkOutput("mon_m_tvalid", m_axis_tvalid, model_occ != 0);
      checkOutput("mon_s_tready", s_axis_tready, model_oor && model_occ != DEPTH && !flush);
      if (held && m_axis_tvalid)
        checkOutput("mon_hold_stable", {m_axis_tlast, m_axis_tdata}, held_word);
    end
    do_push   = s_axis_tvalid && s_axis_tready;
    do_pop    = m_axis_tvalid && m_axis_tready;
    held      = m_axis_tvalid && !m_axis_tready;
    held_word = {m_axis_tlast, m_axis_tdata};
    if (!rstn) begin
      sb.delete();
      model_occ   = 0;
      model_hwm   = 0;
      model_oor   = 1'b0;
      model_valid = 1'b1;
      held        = 1'b0;
    end else if (model_valid) begin
      model_oor = 1'b1;
      if (flush) begin
        sb.delete();
        model_occ = 0;
        model_hwm = 0;
        held      = 1'b0;
      end else begin
        if (do_pop) begin
          if (sb.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL mon_pop_unexpected: got %0h expected no word", {m_axis_tlast, m_axis_tdata});
          end else begin
            exp_w = sb.pop_front();
            checkOutput("mon_rd_word", {m_axis_tlast, m_axis_tdata}, exp_w);
          end
        end
        if (do_push)
          sb.push_back({s_axis_tlast, s_axis_tdata});
        occ_n = model_occ + int'(do_push) - int'(do_pop);
        if (hwm_clr)
          model_hwm = occ_n;
        else if (occ_n > model_hwm)
          model_hwm = occ_n;
        model_occ = occ_n;
      end
    end
  end

  initial begin
    int pushed, cycles, wraps;
    logic v, r;

    // reset values and ready rising one cycle after release
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkReset();
    rstn = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("ready_after_release", s_axis_tready, 1);

    // fill to full with the sink stalled
    $display("[TB] fill to full");
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1, DW'(32'hA0 + i), (i % 4) == 3, 0, 0, 0);
      if (i == 10) checkOutput("afull_at_11", almost_full, 0);
      if (i == 11) checkOutput("afull_at_12", almost_full, 1);
    end
    s_axis_tvalid = 1'b0;
    checkOutput("full_s_tready", s_axis_tready, 0);
    checkOutput("full_occupancy", occupancy, 16);
    checkOutput("full_hwm", hwm, 16);

    // drain back-to-back
    $display("[TB] drain from full");
    for (int k = 0; k < 16; k++) begin
      checkOutput("drain_tvalid", m_axis_tvalid, 1);
      checkOutput("drain_tdata", m_axis_tdata, 32'hA0 + k);
      checkOutput("drain_tlast", m_axis_tlast, (k % 4) == 3);
      applyStimulus(0, 0, 0, 1, 0, 0);
      if (k == 12) checkOutput("aempty_at_3", almost_empty, 0);
      if (k == 13) checkOutput("aempty_at_2", almost_empty, 1);
    end
    checkOutput("drained_tvalid", m_axis_tvalid, 0);
    checkOutput("drained_occupancy", occupancy, 0);

    // first-word latency and full-rate pass-through at occupancy 1
    $display("[TB] latency and streaming");
    applyStimulus(1, 32'h55, 0, 0, 0, 0);
    checkOutput("lat_tvalid", m_axis_tvalid, 1);
    checkOutput("lat_tdata", m_axis_tdata, 32'h55);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1, DW'(32'h100 + i), 0, 1, 0, 0);
      checkOutput("stream_occupancy", occupancy, 1);
      checkOutput("stream_tdata", m_axis_tdata, 32'h100 + i);
    end
    applyStimulus(0, 0, 0, 1, 0, 0);
    checkOutput("stream_end_occ", occupancy, 0);

    // flush with a pop pending
    $display("[TB] flush");
    for (int i = 0; i < 8; i++)
      applyStimulus(1, DW'(32'hB0 + i), 0, 0, 0, 0);
    checkOutput("pre_flush_occ", occupancy, 8);
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b1;
    flush         = 1'b1;
    #1;
    checkOutput("flush_s_tready", s_axis_tready, 0);
    @(posedge clk);
    #1;
    flush         = 1'b0;
    m_axis_tready = 1'b0;
    checkOutput("flush_occupancy", occupancy, 0);
    checkOutput("flush_tvalid", m_axis_tvalid, 0);
    checkOutput("flush_hwm", hwm, 0);
    checkOutput("flush_almost_empty", almost_empty, 1);
    applyStimulus(1, 32'hC3, 0, 0, 0, 0);
    checkOutput("post_flush_tdata", m_axis_tdata, 32'hC3);
    checkOutput("post_flush_hwm", hwm, 1);
    applyStimulus(0, 0, 0, 1, 0, 0);

    // high-water mark clear reloads the current occupancy
    $display("[TB] hwm clear");
    for (int i = 0; i < 3; i++)
      applyStimulus(1, DW'(32'hD0 + i), 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 1, 0, 0);
    checkOutput("hwm_before_clr", hwm, 3);
    applyStimulus(0, 0, 0, 0, 0, 1);
    checkOutput("hwm_after_clr", hwm, 1);
    checkOutput("hwm_clr_tdata", m_axis_tdata, 32'hD2);
    applyStimulus(0, 0, 0, 1, 0, 0);

    // random traffic against the scoreboard
    $display("[TB] random traffic");
    pushed = 0;
    cycles = 0;
    while (pushed < 10000 && cycles < 60000) begin
      v = 1'($urandom_range(0, 1));
      r = 1'($urandom_range(0, 1));
      s_axis_tvalid = v;
      s_axis_tdata  = $urandom;
      s_axis_tlast  = 1'($urandom_range(0, 1));
      m_axis_tready = r;
      #1;
      if (v && s_axis_tready) pushed++;
      @(posedge clk);
      #1;
      cycles++;
    end
    checkOutput("random_words_done", pushed >= 10000, 1);
    wraps = pushed / DEPTH;
    checkOutput("random_wraps_gt_100", wraps > 100, 1);
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b1;
    for (int i = 0; i < 40 && occupancy != 0; i++) begin
      @(posedge clk);
      #1;
    end
    m_axis_tready = 1'b0;
    checkOutput("random_drain_occ", occupancy, 0);
    checkOutput("random_sb_empty", sb.size(), 0);

    // reset mid-operation
    $display("[TB] reset mid-operation");
    for (int i = 0; i < 5; i++)
      applyStimulus(1, DW'(32'hE0 + i), 1, 0, 0, 0);
    checkOutput("pre_reset_occ", occupancy, 5);
    s_axis_tvalid = 1'b0;
    rstn = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkReset();
    rstn = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("ready_after_rerelease", s_axis_tready, 1);
    applyStimulus(0, 0, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
